// File: rtl/result_arbiter.sv
// rtl/result_arbiter.sv - two-source round-robin feeder for the OR-combining result bus
// Each source has a 2-entry FIFO; one granted word per cycle is driven onto its own bus with a one-hot ren.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module result_arbiter #(
  parameter int DATA_WIDTH = `DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_src0_valid,
  input  logic [DATA_WIDTH-1:0] i_src0_data,
  output logic                  o_src0_ready,
  input  logic                  i_src1_valid,
  input  logic [DATA_WIDTH-1:0] i_src1_data,
  output logic                  o_src1_ready,
  input  logic                  i_wb_ready,
  output logic [DATA_WIDTH-1:0] o_raw_bus_0,
  output logic [DATA_WIDTH-1:0] o_raw_bus_1,
  output logic                  o_raw_bus_0_ren,
  output logic                  o_raw_bus_1_ren,
  output logic                  o_busy
);

  localparam int FIFO_DEPTH = 2;
  localparam logic [1:0] FULL_COUNT = 2'(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] mem [2][FIFO_DEPTH];
  logic [1:0]            count [2];
  logic                  wr_ptr [2];
  logic                  rd_ptr [2];
  logic                  last_grant;

  logic [1:0]            src_valid;
  logic [1:0]            src_ready;
  logic [1:0]            nonempty;
  logic [1:0]            push;
  logic [1:0]            grant;
  logic [DATA_WIDTH-1:0] src_data [2];

  assign src_valid   = {i_src1_valid, i_src0_valid};
  assign src_data[0] = i_src0_data;
  assign src_data[1] = i_src1_data;

  // Ready comes from the registered count only, so a full FIFO refuses even while being popped.
  always_comb begin
    src_ready = 2'b00;
    nonempty  = 2'b00;
    push      = 2'b00;
    for (int s = 0; s < 2; s++) begin
      src_ready[s] = (count[s] != FULL_COUNT);
      nonempty[s]  = (count[s] != 2'd0);
      push[s]      = src_valid[s] && src_ready[s];
    end
  end

  // On contention, the source not granted last time wins.
  always_comb begin
    grant = 2'b00;
    if (i_wb_ready) begin
      if (nonempty[0] && (!nonempty[1] || last_grant)) begin
        grant = 2'b01;
      end else if (nonempty[1]) begin
        grant = 2'b10;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int s = 0; s < 2; s++) begin
      if (push[s]) begin
        mem[s][wr_ptr[s]] <= src_data[s];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      for (int s = 0; s < 2; s++) begin
        count[s]  <= 2'd0;
        wr_ptr[s] <= 1'b0;
        rd_ptr[s] <= 1'b0;
      end
      last_grant      <= 1'b1;
      o_raw_bus_0     <= '0;
      o_raw_bus_1     <= '0;
      o_raw_bus_0_ren <= 1'b0;
      o_raw_bus_1_ren <= 1'b0;
    end else begin
      for (int s = 0; s < 2; s++) begin
        if (push[s]) begin
          wr_ptr[s] <= ~wr_ptr[s];
        end
        if (grant[s]) begin
          rd_ptr[s] <= ~rd_ptr[s];
        end
        case ({push[s], grant[s]})
          2'b10:   count[s] <= count[s] + 2'd1;
          2'b01:   count[s] <= count[s] - 2'd1;
          default: count[s] <= count[s];
        endcase
      end
      if (grant[0]) begin
        last_grant <= 1'b0;
      end else if (grant[1]) begin
        last_grant <= 1'b1;
      end
      // Non-granted buses must read zero for the downstream OR-combine.
      o_raw_bus_0     <= grant[0] ? mem[0][rd_ptr[0]] : '0;
      o_raw_bus_1     <= grant[1] ? mem[1][rd_ptr[1]] : '0;
      o_raw_bus_0_ren <= grant[0];
      o_raw_bus_1_ren <= grant[1];
    end
  end

  assign o_src0_ready = src_ready[0];
  assign o_src1_ready = src_ready[1];
  assign o_busy = nonempty[0] || nonempty[1] || o_raw_bus_0_ren || o_raw_bus_1_ren;

endmodule

// File: tb/tb_result_arbiter.sv
// tb/tb_result_arbiter.sv - directed self-checking bench for result_arbiter
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_result_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_src0_valid;
  logic [31:0] i_src0_data;
  logic        o_src0_ready;
  logic        i_src1_valid;
  logic [31:0] i_src1_data;
  logic        o_src1_ready;
  logic        i_wb_ready;
  logic [31:0] o_raw_bus_0;
  logic [31:0] o_raw_bus_1;
  logic        o_raw_bus_0_ren;
  logic        o_raw_bus_1_ren;
  logic        o_busy;

  int checks = 0;
  int failures = 0;

  result_arbiter #(.DATA_WIDTH(32)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .i_src0_valid    (i_src0_valid),
    .i_src0_data     (i_src0_data),
    .o_src0_ready    (o_src0_ready),
    .i_src1_valid    (i_src1_valid),
    .i_src1_data     (i_src1_data),
    .o_src1_ready    (o_src1_ready),
    .i_wb_ready      (i_wb_ready),
    .o_raw_bus_0     (o_raw_bus_0),
    .o_raw_bus_1     (o_raw_bus_1),
    .o_raw_bus_0_ren (o_raw_bus_0_ren),
    .o_raw_bus_1_ren (o_raw_bus_1_ren),
    .o_busy          (o_busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_ren0"}, {31'd0, o_raw_bus_0_ren}, 32'd0);
    chk({tag, "_ren1"}, {31'd0, o_raw_bus_1_ren}, 32'd0);
    chk({tag, "_bus0"}, o_raw_bus_0, 32'd0);
    chk({tag, "_bus1"}, o_raw_bus_1, 32'd0);
  endtask

  logic [31:0] exp_word [8];
  logic        exp_src  [8];
  int          idx0, idx1, got;
  logic        acc0, acc1;

  initial begin
    rst_n = 1'b1;
    i_src0_valid = 1'b0; i_src0_data = '0;
    i_src1_valid = 1'b0; i_src1_data = '0;
    i_wb_ready = 1'b0;
    tick();
    tick();
    chk_idle("reset");
    chk("reset_ready0", {31'd0, o_src0_ready}, 32'd1);
    chk("reset_ready1", {31'd0, o_src1_ready}, 32'd1);
    chk("reset_busy", {31'd0, o_busy}, 32'd0);

    // single push
    rst_n = 1'b0;
    i_wb_ready = 1'b1;
    i_src0_valid = 1'b1; i_src0_data = 32'hA5A5_0001;
    tick();
    i_src0_valid = 1'b0; i_src0_data = '0;
    chk_idle("single_e1");
    chk("single_e1_busy", {31'd0, o_busy}, 32'd1);
    tick();
    chk("single_ren0", {31'd0, o_raw_bus_0_ren}, 32'd1);
    chk("single_bus0", o_raw_bus_0, 32'hA5A5_0001);
    chk("single_ren1", {31'd0, o_raw_bus_1_ren}, 32'd0);
    chk("single_bus1", o_raw_bus_1, 32'd0);
    tick();
    chk_idle("single_e3");
    chk("single_e3_busy", {31'd0, o_busy}, 32'd0);

    // contention from a fresh reset: src0 first, strict alternation
    rst_n = 1'b1;
    tick();
    rst_n = 1'b0;
    for (int k = 0; k < 4; k++) begin
      exp_word[2*k]   = 32'h10 + 32'(k); exp_src[2*k]   = 1'b0;
      exp_word[2*k+1] = 32'h20 + 32'(k); exp_src[2*k+1] = 1'b1;
    end
    idx0 = 0; idx1 = 0; got = 0;
    for (int cyc = 0; cyc < 30 && got < 8; cyc++) begin
      i_src0_valid = (idx0 < 4);
      i_src0_data  = (idx0 < 4) ? 32'h10 + 32'(idx0) : 32'd0;
      i_src1_valid = (idx1 < 4);
      i_src1_data  = (idx1 < 4) ? 32'h20 + 32'(idx1) : 32'd0;
      acc0 = i_src0_valid && o_src0_ready;
      acc1 = i_src1_valid && o_src1_ready;
      tick();
      if (acc0) idx0++;
      if (acc1) idx1++;
      chk("cont_onehot", {31'd0, o_raw_bus_0_ren & o_raw_bus_1_ren}, 32'd0);
      if (o_raw_bus_0_ren || o_raw_bus_1_ren) begin
        if (got < 8) begin
          chk("cont_src", {31'd0, o_raw_bus_1_ren}, {31'd0, exp_src[got]});
          chk("cont_word", o_raw_bus_0 | o_raw_bus_1, exp_word[got]);
          chk("cont_idle_bus", o_raw_bus_0_ren ? o_raw_bus_1 : o_raw_bus_0, 32'd0);
        end
        got++;
      end
    end
    chk("cont_count", 32'(got), 32'd8);
    i_src0_valid = 1'b0; i_src1_valid = 1'b0;
    i_src0_data = '0; i_src1_data = '0;
    tick();
    chk_idle("cont_drain");
    chk("cont_drain_busy", {31'd0, o_busy}, 32'd0);

    // push and pop on the same src0 FIFO while it holds one word
    i_wb_ready = 1'b0;
    i_src0_valid = 1'b1; i_src0_data = 32'h41;
    tick();
    chk_idle("pp_hold");
    i_wb_ready = 1'b1;
    i_src0_data = 32'h42;
    tick();
    i_src0_valid = 1'b0; i_src0_data = '0;
    chk("pp_bus0_old", o_raw_bus_0, 32'h41);
    chk("pp_ren0_old", {31'd0, o_raw_bus_0_ren}, 32'd1);
    chk("pp_ready0", {31'd0, o_src0_ready}, 32'd1);
    tick();
    chk("pp_bus0_new", o_raw_bus_0, 32'h42);
    chk("pp_ren0_new", {31'd0, o_raw_bus_0_ren}, 32'd1);
    tick();
    chk_idle("pp_done");
    chk("pp_done_busy", {31'd0, o_busy}, 32'd0);

    // backpressure on src1
    i_wb_ready = 1'b0;
    i_src1_valid = 1'b1; i_src1_data = 32'h31;
    chk("bp_ready_a", {31'd0, o_src1_ready}, 32'd1);
    tick();
    i_src1_data = 32'h32;
    chk("bp_ready_b", {31'd0, o_src1_ready}, 32'd1);
    tick();
    i_src1_data = 32'h33;
    chk("bp_ready_full", {31'd0, o_src1_ready}, 32'd0);
    tick();
    chk("bp_ready_held", {31'd0, o_src1_ready}, 32'd0);
    chk_idle("bp_stall");
    chk("bp_busy", {31'd0, o_busy}, 32'd1);
    i_wb_ready = 1'b1;
    tick();
    chk("bp_w1", o_raw_bus_1, 32'h31);
    chk("bp_w1_ren", {31'd0, o_raw_bus_1_ren}, 32'd1);
    chk("bp_ready_back", {31'd0, o_src1_ready}, 32'd1);
    tick();
    i_src1_valid = 1'b0; i_src1_data = '0;
    chk("bp_w2", o_raw_bus_1, 32'h32);
    tick();
    chk("bp_w3", o_raw_bus_1, 32'h33);
    chk("bp_w3_ren0", {31'd0, o_raw_bus_0_ren}, 32'd0);
    tick();
    chk_idle("bp_done");
    chk("bp_done_busy", {31'd0, o_busy}, 32'd0);

    // mid-operation reset; last grant before reset is src0
    i_wb_ready = 1'b0;
    i_src0_valid = 1'b1; i_src0_data = 32'h51;
    i_src1_valid = 1'b1; i_src1_data = 32'h61;
    tick();
    i_src0_data = 32'h52; i_src1_data = 32'h62;
    tick();
    i_src0_valid = 1'b0; i_src1_valid = 1'b0;
    i_src0_data = '0; i_src1_data = '0;
    chk("mr_full0", {31'd0, o_src0_ready}, 32'd0);
    chk("mr_full1", {31'd0, o_src1_ready}, 32'd0);
    i_wb_ready = 1'b1;
    tick();
    chk("mr_pre_bus0", o_raw_bus_0, 32'h51);
    chk("mr_pre_ren0", {31'd0, o_raw_bus_0_ren}, 32'd1);
    rst_n = 1'b1;
    tick();
    rst_n = 1'b0;
    chk_idle("mr_reset");
    chk("mr_ready0", {31'd0, o_src0_ready}, 32'd1);
    chk("mr_ready1", {31'd0, o_src1_ready}, 32'd1);
    chk("mr_busy", {31'd0, o_busy}, 32'd0);
    i_src0_valid = 1'b1; i_src0_data = 32'h71;
    i_src1_valid = 1'b1; i_src1_data = 32'h81;
    tick();
    i_src0_valid = 1'b0; i_src1_valid = 1'b0;
    i_src0_data = '0; i_src1_data = '0;
    chk_idle("mr_post_e1");
    tick();
    chk("mr_first_ren0", {31'd0, o_raw_bus_0_ren}, 32'd1);
    chk("mr_first_bus0", o_raw_bus_0, 32'h71);
    chk("mr_first_bus1", o_raw_bus_1, 32'd0);
    tick();
    chk("mr_second_ren1", {31'd0, o_raw_bus_1_ren}, 32'd1);
    chk("mr_second_bus1", o_raw_bus_1, 32'h81);
    chk("mr_second_ren0", {31'd0, o_raw_bus_0_ren}, 32'd0);
    tick();
    chk_idle("mr_done");
    chk("mr_done_busy", {31'd0, o_busy}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/result_arbiter.md
# result_arbiter

Upstream feeder for `result_bus`. It accepts results from two producers (source 0: ALU path, source 1: multiply/divide path) through valid/ready handshakes and holds each in its own 2-entry FIFO. Each cycle it grants at most one source, round-robin. It drives that source's registered data and a one-hot read enable (`o_raw_bus_0_ren` / `o_raw_bus_1_ren`) straight into the OR-combining result bus.

## Interface

Parameters:
- `DATA_WIDTH`, default `` `DATA_WIDTH `` (32): result word width.
- `FIFO_DEPTH`, fixed at 2: entries per source (not overridable).

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst_n`  in  1  synchronous, active-high reset. The name is kept per codebase convention; 1 = reset.
- `i_src0_valid`  in  1  source 0 presents a result.
- `i_src0_data`  in  DATA_WIDTH  source 0 result.
- `o_src0_ready`  out  1  source 0 FIFO can accept.
- `i_src1_valid`  in  1  source 1 presents a result.
- `i_src1_data`  in  DATA_WIDTH  source 1 result.
- `o_src1_ready`  out  1  source 1 FIFO can accept.
- `i_wb_ready`  in  1  downstream writeback can take a result this cycle.
- `o_raw_bus_0`  out  DATA_WIDTH  granted source-0 data, else 0.
- `o_raw_bus_1`  out  DATA_WIDTH  granted source-1 data, else 0.
- `o_raw_bus_0_ren`  out  1  source-0 word valid on bus this cycle.
- `o_raw_bus_1_ren`  out  1  source-1 word valid on bus this cycle.
- `o_busy`  out  1  either FIFO non-empty or a ren is asserted.

## Operation

- **Per-source FIFO:** 2 entries, read/write pointer plus 2-bit count (0..2).
  - Push when `valid && ready`.
  - `o_srcX_ready = (count != 2)`, decoded from registered count. It does not depend on a same-cycle pop.
- **Arbitration** is combinational on current FIFO state. `grant` is computed only when `i_wb_ready = 1`:
  - only one FIFO non-empty → grant it;
  - both non-empty → grant the source not named by `last_grant`;
  - both empty or `i_wb_ready = 0` → no grant.
- **On a grant** at edge E:
  - pop the head of that FIFO;
  - load its data into that bus register;
  - set its ren register to 1;
  - set `last_grant` to that source.
- **Non-granted bus** register loads 0 and its ren loads 0.
- **No grant:** both ren registers and both bus registers load 0. Buses are always 0 when not enabled, which is required for OR-combining.
- **One-hot rule:** `o_raw_bus_0_ren` and `o_raw_bus_1_ren` are never both 1.
- **Simultaneous push and pop** on the same FIFO:
  - count unchanged;
  - ordering preserved (pop returns the older entry).
- A push into a count-1 FIFO in the same cycle as its pop is legal.
- **Reset:**
  - FIFOs emptied, pointers and counts 0;
  - `last_grant = 1`, so source 0 wins the first contention;
  - all outputs 0 except `o_src0_ready = o_src1_ready = 1` in the cycle after reset deasserts;
  - in-flight FIFO contents are discarded;
  - reset asserted mid-operation clears ren/bus on the next edge.

## Timing

- **Latency:** handshake at edge E0 → earliest grant at edge E0+1 → ren/bus high during the cycle after E0+1. Minimum 2 edges from accepted input to visible output.
- **Throughput:** 1 result per cycle total across both sources while `i_wb_ready = 1`. Each source sustains 1 per cycle if the other is idle.
- **ren pulse:** one cycle per granted word. Back-to-back grants give continuous ren.
- **`i_wb_ready` low** at edge E: no pop; ren low after E. FIFO contents are held, and FIFOs keep accepting until full.
- **`o_busy`** is combinational OR of `(count0 != 0)`, `(count1 != 0)`, and both ren registers.

## Test plan

- **Single push:** reset, then src0 push 0xA5A50001 at edge 1, `i_wb_ready = 1`.
  - Required: ren0 = 1, bus0 = 0xA5A50001, bus1 = 0 for exactly one cycle after edge 2.
  - Required: ren1 = 0 throughout.
- **Contention:** both sources push every cycle, src0 values 0x10..0x13, src1 values 0x20..0x23.
  - Required grant order on bus: 0x10, 0x20, 0x11, 0x21, … with ren strictly one-hot.
  - Required: no word lost or reordered.
- **Backpressure:** `i_wb_ready = 0`, src1 pushes 3 consecutive cycles.
  - Required: `o_src1_ready` drops after the 2nd accept; 3rd word is held by the source.
  - Raise `i_wb_ready` → required: words emerge in order, then the 3rd is accepted.
- **Push/pop same cycle:** src0 FIFO at count 1 with `i_wb_ready = 1` and a new push in the same cycle.
  - Required: count stays 1; older word output first.
- **Mid-operation reset:** both FIFOs full, then assert `rst_n = 1` for one cycle.
  - Required: next cycle ren0 = ren1 = 0, buses 0, both readies 1, `o_busy` = 0.
  - Required: on the first subsequent contention, src0 is granted first.
